// File: rtl/connector_pkg.sv
// Shared connector types and sizing used between the CVA6 commit path and the itype detector.
package connector_pkg;

  localparam int XLEN     = 64;
  localparam int BQ_DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
  } bq_entry_t;

endpackage

// File: rtl/branch_queue.sv
// Circular FIFO of resolved control-flow instructions; the head is the oldest
// outstanding discontinuity and is retired when its PC commits.
module branch_queue
  import connector_pkg::*;
#(
  parameter int DEPTH = BQ_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            resolve_valid_i,
  input  logic [XLEN-1:0] resolve_pc_i,
  input  logic            resolve_taken_i,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  output logic [XLEN-1:0] disc_pc_o,
  output logic            taken_o,
  output logic            pending_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  bq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             overflow_q;
  logic             push;
  logic             pop;
  bq_entry_t        head;

  assign empty_o    = (count == '0);
  assign full_o     = (count == FULL_CNT);
  assign pending_o  = !empty_o;
  assign overflow_o = overflow_q;
  assign head       = mem[rd_ptr];

  // Head fields are masked so an empty queue never exposes stale storage.
  assign disc_pc_o  = pending_o ? head.pc    : '0;
  assign taken_o    = pending_o ? head.taken : 1'b0;

  assign pop  = commit_valid_i && !empty_o && (commit_pc_i == disc_pc_o);
  assign push = resolve_valid_i && (!full_o || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (resolve_valid_i && full_o && !pop)
        overflow_q <= 1'b1;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i)
      mem[wr_ptr] <= '{pc: resolve_pc_i, taken: resolve_taken_i};
  end

endmodule

// File: tb/tb_branch_queue.sv
// Directed bench for branch_queue: push/commit ordering, full/overflow, wrap, flush and async reset.
module tb_branch_queue;
  import connector_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            resolve_valid_i;
  logic [XLEN-1:0] resolve_pc_i;
  logic            resolve_taken_i;
  logic            commit_valid_i;
  logic [XLEN-1:0] commit_pc_i;
  logic [XLEN-1:0] disc_pc_o;
  logic            taken_o;
  logic            pending_o;
  logic            empty_o;
  logic            full_o;
  logic            overflow_o;

  int tests = 0;
  int fails = 0;

  branch_queue #(.DEPTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i), .commit_valid_i(commit_valid_i),
    .commit_pc_i(commit_pc_i), .disc_pc_o(disc_pc_o), .taken_o(taken_o),
    .pending_o(pending_o), .empty_o(empty_o), .full_o(full_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},    XLEN'(empty_o),    XLEN'(1));
    check({tag, "_pending"},  XLEN'(pending_o),  XLEN'(0));
    check({tag, "_full"},     XLEN'(full_o),     XLEN'(0));
    check({tag, "_taken"},    XLEN'(taken_o),    XLEN'(0));
    check({tag, "_disc"},     disc_pc_o,         XLEN'(0));
    check({tag, "_overflow"}, XLEN'(overflow_o), XLEN'(0));
  endtask

  // One clock: apply inputs, take the edge, sample 1ns later and release inputs.
  task automatic cyc(input logic rv, input logic [XLEN-1:0] rpc, input logic rt,
                     input logic cv, input logic [XLEN-1:0] cpc, input logic fl);
    resolve_valid_i = rv; resolve_pc_i = rpc; resolve_taken_i = rt;
    commit_valid_i  = cv; commit_pc_i  = cpc; flush_i = fl;
    @(posedge clk_i); #1;
    resolve_valid_i = 1'b0; commit_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic t);
    cyc(1'b1, pc, t, 1'b0, '0, 1'b0);
  endtask

  task automatic commit(input logic [XLEN-1:0] pc);
    cyc(1'b0, '0, 1'b0, 1'b1, pc, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0;
    resolve_valid_i = 1'b0; resolve_pc_i = '0; resolve_taken_i = 1'b0;
    commit_valid_i = 1'b0; commit_pc_i = '0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check("idle_empty",   XLEN'(empty_o),   XLEN'(1));
      check("idle_pending", XLEN'(pending_o), XLEN'(0));
      check("idle_disc",    disc_pc_o,        XLEN'(0));
    end

    // Single push then matching commit
    push(64'h1000, 1'b1);
    check("p1_disc",    disc_pc_o,        64'h1000);
    check("p1_taken",   XLEN'(taken_o),   XLEN'(1));
    check("p1_pending", XLEN'(pending_o), XLEN'(1));
    commit(64'h1000);
    check("c1_empty", XLEN'(empty_o), XLEN'(1));
    check("c1_disc",  disc_pc_o,      XLEN'(0));

    // Ordered head, non-matching commit ignored
    push(64'h2000, 1'b0);
    push(64'h2008, 1'b1);
    push(64'h2010, 1'b0);
    check("p3_disc", disc_pc_o, 64'h2000);
    commit(64'h2004);
    check("nomatch_disc",  disc_pc_o,      64'h2000);
    check("nomatch_taken", XLEN'(taken_o), XLEN'(0));
    commit(64'h2000);
    check("c2_disc",  disc_pc_o,      64'h2008);
    check("c2_taken", XLEN'(taken_o), XLEN'(1));
    commit(64'h2008);
    check("c3_disc", disc_pc_o, 64'h2010);
    commit(64'h2010);
    check("c4_empty", XLEN'(empty_o), XLEN'(1));

    // Fill, overflow, push+pop while full
    for (int i = 0; i < 8; i++) begin
      check("fill_notfull", XLEN'(full_o), XLEN'(0));
      push(64'h3000 + 64'(i * 4), 1'b0);
    end
    check("fill_full",     XLEN'(full_o),     XLEN'(1));
    check("fill_overflow", XLEN'(overflow_o), XLEN'(0));
    push(64'h4000, 1'b1);
    check("ovf_flag", XLEN'(overflow_o), XLEN'(1));
    check("ovf_full", XLEN'(full_o),     XLEN'(1));
    check("ovf_head", disc_pc_o,         64'h3000);
    cyc(1'b1, 64'h4004, 1'b1, 1'b1, 64'h3000, 1'b0);
    check("pp_full_head", disc_pc_o,         64'h3004);
    check("pp_full_full", XLEN'(full_o),     XLEN'(1));
    check("pp_full_ovf",  XLEN'(overflow_o), XLEN'(1));
    for (int i = 1; i < 8; i++) begin
      check("drain_head", disc_pc_o, 64'h3000 + 64'(i * 4));
      commit(64'h3000 + 64'(i * 4));
      check("drain_notfull", XLEN'(full_o), XLEN'(0));
    end
    check("drain_last_head",  disc_pc_o,      64'h4004);
    check("drain_last_taken", XLEN'(taken_o), XLEN'(1));
    commit(64'h4004);
    check("drain_empty", XLEN'(empty_o), XLEN'(1));

    // 20 push/pop cycles across pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 64'h5000 + 64'(i * 8), i[0], (i != 0), 64'h5000 + 64'((i - 1) * 8), 1'b0);
      check("wrap_head",    disc_pc_o,        64'h5000 + 64'(i * 8));
      check("wrap_taken",   XLEN'(taken_o),   XLEN'(i[0]));
      check("wrap_pending", XLEN'(pending_o), XLEN'(1));
    end
    commit(64'h5000 + 64'(19 * 8));
    check("wrap_empty", XLEN'(empty_o), XLEN'(1));

    // Flush with three entries and a same-cycle push
    push(64'h6000, 1'b1);
    push(64'h6004, 1'b0);
    push(64'h6008, 1'b1);
    check("pre_flush_head", disc_pc_o, 64'h6000);
    cyc(1'b1, 64'h600c, 1'b1, 1'b1, 64'h6000, 1'b1);
    check("flush_empty",   XLEN'(empty_o),    XLEN'(1));
    check("flush_pending", XLEN'(pending_o),  XLEN'(0));
    check("flush_disc",    disc_pc_o,         XLEN'(0));
    check("flush_ovf",     XLEN'(overflow_o), XLEN'(1));
    push(64'h7000, 1'b0);
    check("post_flush_head", disc_pc_o, 64'h7000);

    // Asynchronous reset mid-stream
    push(64'h7008, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk_i); #1;
    check_reset_outputs("rst_held");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("rst_released");
    push(64'h8000, 1'b1);
    check("post_rst_head",  disc_pc_o,      64'h8000);
    check("post_rst_taken", XLEN'(taken_o), XLEN'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
